bar_capture_bank: RTL and testbench



---
 rtl/bar_capture_bank.sv | 178 +++++++++++++++++
 tb/tb_bar_capture_bank.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bar_capture_bank.sv
// Host-decoded register bank with a capture RAM filled by a triggered capture engine.
// state | meaning: IDLE idle, ARMED waiting for trigger, CAPTURE writing samples, DONE one-shot finished
module bar_capture_bank #(
    parameter int unsigned AW           = 24,
    parameter int unsigned DW           = 32,
    parameter int unsigned SW           = 8,
    parameter int unsigned RAM_AW       = 6,
    parameter int unsigned RAM_BASE     = 'h100,
    parameter int unsigned SCRATCH_INIT = 'h42
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          demo_sig,
    input  logic [SW-1:0] sample,
    input  logic [AW-1:0] gb_addr,
    input  logic [DW-1:0] gb_wdata,
    input  logic          gb_we,
    input  logic          gb_re,
    output logic [DW-1:0] gb_rdata,
    output logic          gb_rvalid,
    output logic          done
);

    localparam int unsigned   DEPTH       = 2 ** RAM_AW;
    localparam logic [AW-1:0] BASE_A      = AW'(RAM_BASE);
    localparam logic [AW-1:0] ADDR_CTRL   = AW'(32'h0);
    localparam logic [AW-1:0] ADDR_STATUS = AW'(32'h1);
    localparam logic [AW-1:0] ADDR_SCR    = AW'(32'h2);
    localparam logic [AW-1:0] ADDR_CAPLEN = AW'(32'h3);
    localparam logic [AW-1:0] ADDR_CAPCNT = AW'(32'h4);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state_q, state_nxt;
    logic [RAM_AW-1:0]   wptr_q, wptr_nxt;
    logic [RAM_AW-1:0]   caplen_q;
    logic [DW-1:0]       capcnt_q;
    logic [DW-1:0]       scratch_q;
    logic                cont_q;
    logic                demo_sig_q;
    logic [SW-1:0]       mem [DEPTH];

    logic                sel_ctrl, sel_status, sel_scr, sel_caplen, sel_capcnt, sel_ram;
    logic [RAM_AW-1:0]   ram_idx;
    logic                ctrl_we, arm_cmd, abort_cmd, trig;
    logic                eng_we, cap_last, host_ram_we;
    logic [DW-1:0]       status_word, rd_mux;

    assign sel_ctrl   = (gb_addr == ADDR_CTRL);
    assign sel_status = (gb_addr == ADDR_STATUS);
    assign sel_scr    = (gb_addr == ADDR_SCR);
    assign sel_caplen = (gb_addr == ADDR_CAPLEN);
    assign sel_capcnt = (gb_addr == ADDR_CAPCNT);
    assign sel_ram    = (gb_addr[AW-1:RAM_AW] == BASE_A[AW-1:RAM_AW]);
    assign ram_idx    = gb_addr[RAM_AW-1:0];

    assign ctrl_we   = gb_we & sel_ctrl;
    assign arm_cmd   = ctrl_we & gb_wdata[0];
    assign abort_cmd = ctrl_we & gb_wdata[1];
    assign trig      = demo_sig & ~demo_sig_q;

    // The engine owns the RAM outside IDLE/DONE, so host writes are dropped there.
    assign host_ram_we = gb_we & sel_ram & ((state_q == IDLE) | (state_q == DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            done       <= 1'b0;
            demo_sig_q <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            wptr_q     <= wptr_nxt;
            done       <= (state_nxt == DONE);
            demo_sig_q <= demo_sig;
        end
    end

    always_comb begin
        state_nxt = state_q;
        wptr_nxt  = wptr_q;
        eng_we    = 1'b0;
        cap_last  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (arm_cmd) begin
                    state_nxt = ARMED;
                    wptr_nxt  = '0;
                end
            end
            ARMED, CAPTURE: begin
                if (state_q == CAPTURE || trig) begin
                    eng_we   = 1'b1;
                    wptr_nxt = wptr_q + RAM_AW'(1);
                    if (wptr_q == caplen_q) begin
                        cap_last = 1'b1;
                        if (cont_q) begin
                            state_nxt = ARMED;
                            wptr_nxt  = '0;
                        end else begin
                            state_nxt = DONE;
                        end
                    end else begin
                        state_nxt = CAPTURE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort_cmd) begin
            state_nxt = IDLE;
            wptr_nxt  = wptr_q;
            eng_we    = 1'b0;
            cap_last  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cont_q    <= 1'b0;
            scratch_q <= DW'(SCRATCH_INIT);
            caplen_q  <= '1;
            capcnt_q  <= '0;
        end else begin
            if (ctrl_we) cont_q <= gb_wdata[2];
            if (gb_we && sel_scr) scratch_q <= gb_wdata;
            if (gb_we && sel_caplen) caplen_q <= gb_wdata[RAM_AW-1:0];
            if (cap_last) capcnt_q <= capcnt_q + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (eng_we) begin
            mem[wptr_q] <= sample;
        end else if (host_ram_we) begin
            mem[ram_idx] <= gb_wdata[SW-1:0];
        end
    end

    always_comb begin
        status_word               = '0;
        status_word[1:0]          = state_q;
        status_word[2]            = cont_q;
        status_word[RAM_AW+7:8]   = wptr_q;
    end

    always_comb begin
        rd_mux = '0;
        if (sel_ram) begin
            rd_mux[SW-1:0] = mem[ram_idx];
        end else if (sel_status) begin
            rd_mux = status_word;
        end else if (sel_scr) begin
            rd_mux = scratch_q;
        end else if (sel_caplen) begin
            rd_mux[RAM_AW-1:0] = caplen_q;
        end else if (sel_capcnt) begin
            rd_mux = capcnt_q;
        end
    end

    // Read data is registered from pre-edge contents, so a same-cycle write reads old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gb_rdata  <= '0;
            gb_rvalid <= 1'b0;
        end else begin
            gb_rvalid <= gb_re;
            if (gb_re) gb_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_bar_capture_bank.sv
// Self-checking bench for bar_capture_bank: spec-level model compared every cycle plus literal checks.
module tb_bar_capture_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        demo_sig;
    logic [7:0]  sample;
    logic [23:0] gb_addr;
    logic [31:0] gb_wdata;
    logic        gb_we, gb_re;
    logic [31:0] gb_rdata;
    logic        gb_rvalid;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;
    logic done_seen = 1'b0;
    logic [31:0] d;

    bar_capture_bank dut (
        .clk(clk), .rst_n(rst_n), .demo_sig(demo_sig), .sample(sample),
        .gb_addr(gb_addr), .gb_wdata(gb_wdata), .gb_we(gb_we), .gb_re(gb_re),
        .gb_rdata(gb_rdata), .gb_rvalid(gb_rvalid), .done(done)
    );

    always #5 clk = ~clk;

    // Model state: st 0 idle, 1 armed, 2 capture, 3 done
    int          m_st, m_wptr, m_caplen;
    logic        m_cont, m_sig_q, m_rvalid, m_done;
    logic [31:0] m_scratch, m_capcnt, m_rdata;
    logic [7:0]  m_ram [64];

    function automatic logic [31:0] model_read(input int a);
        if (a == 1) return 32'(m_st) | (32'(m_cont) << 2) | (32'(m_wptr) << 8);
        if (a == 2) return m_scratch;
        if (a == 3) return 32'(m_caplen);
        if (a == 4) return m_capcnt;
        if (a >= 256 && a < 320) return {24'h0, m_ram[a-256]};
        return 32'h0;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model_step
        int a;
        bit trg, arm, abort, host_ok, old_cont;
        if (!rst_n) begin
            m_st = 0; m_wptr = 0; m_caplen = 63; m_cont = 0; m_sig_q = 0;
            m_rvalid = 0; m_done = 0; m_scratch = 32'h42; m_capcnt = 0; m_rdata = 0;
        end else begin
            a = int'(gb_addr);
            m_rvalid = gb_re;
            if (gb_re) m_rdata = model_read(a);
            trg = demo_sig && !m_sig_q;
            m_sig_q = demo_sig;
            arm = gb_we && a == 0 && gb_wdata[0];
            abort = gb_we && a == 0 && gb_wdata[1];
            host_ok = (m_st == 0 || m_st == 3);
            old_cont = m_cont;
            if (abort) begin
                m_st = 0;
            end else if (m_st == 0 || m_st == 3) begin
                if (arm) begin m_st = 1; m_wptr = 0; end
            end else if (m_st == 2 || trg) begin
                m_ram[m_wptr] = sample;
                if (m_wptr == m_caplen) begin
                    m_capcnt = m_capcnt + 1;
                    m_st = old_cont ? 1 : 3;
                    m_wptr = old_cont ? 0 : (m_wptr + 1) % 64;
                end else begin
                    m_st = 2;
                    m_wptr = m_wptr + 1;
                end
            end
            if (gb_we) begin
                if (a == 0) m_cont = gb_wdata[2];
                if (a == 2) m_scratch = gb_wdata;
                if (a == 3) m_caplen = int'(gb_wdata & 32'h3f);
                if (a >= 256 && a < 320 && host_ok) m_ram[a-256] = gb_wdata[7:0];
            end
            m_done = (m_st == 3);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_rvalid", 32'(gb_rvalid), 32'(m_rvalid));
            if (m_rvalid) check("model_rdata", gb_rdata, m_rdata);
            check("model_done", 32'(done), 32'(m_done));
            if (done) done_seen = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int a, input logic [31:0] v);
        gb_addr = 24'(a); gb_wdata = v; gb_we = 1'b1;
        tick();
        gb_we = 1'b0;
    endtask

    task automatic host_read(input int a, output logic [31:0] v);
        gb_addr = 24'(a); gb_re = 1'b1;
        tick();
        gb_re = 1'b0;
        check("rvalid_pulse", 32'(gb_rvalid), 32'h1);
        v = gb_rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; demo_sig = 0; sample = 0; gb_addr = 0; gb_wdata = 0; gb_we = 0; gb_re = 0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_done", 32'(done), 32'h0);
        check("rst_rvalid", 32'(gb_rvalid), 32'h0);
        check("rst_rdata", gb_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        host_read(2, d); check("rst_scratch", d, 32'h42);
        host_read(3, d); check("rst_caplen", d, 32'h3f);
        host_read(4, d); check("rst_capcnt", d, 32'h0);
        host_read(1, d); check("rst_status", d, 32'h0);
        host_read(7, d); check("rd_unmapped", d, 32'h0);
        host_read(0, d); check("rd_ctrl", d, 32'h0);

        gb_addr = 24'h2; gb_wdata = 32'hDEADBEEF; gb_we = 1; gb_re = 1;
        tick();
        gb_we = 0; gb_re = 0;
        check("wr_rd_same_old", gb_rdata, 32'h42);
        host_read(2, d); check("scratch_new", d, 32'hDEADBEEF);

        for (int i = 0; i < 64; i++) host_write(256 + i, 32'hFFFFFF10 + 32'(i));
        host_read(256 + 5, d); check("ram_init5", d, 32'h15);

        host_write(3, 32'hFFFFFFC3);
        host_read(3, d); check("caplen_masked", d, 32'h3);
        host_write(0, 32'h1);
        host_read(1, d); check("status_armed", d, 32'h1);
        demo_sig = 1; sample = 8'hA0; tick();
        demo_sig = 0; sample = 8'hA1; check("done_t1", 32'(done), 32'h0); tick();
        sample = 8'hA2; tick();
        sample = 8'hA3; check("done_t3", 32'(done), 32'h0); tick();
        sample = 8'hA4; check("done_t4", 32'(done), 32'h1); tick();
        sample = 8'h00;
        for (int i = 0; i < 4; i++) begin
            host_read(256 + i, d); check("cap_ram", d, 32'hA0 + 32'(i));
        end
        host_read(256 + 4, d); check("cap_ram4_kept", d, 32'h14);
        host_read(4, d); check("capcnt1", d, 32'h1);
        host_read(1, d); check("status_done", d, 32'h403);

        host_write(3, 32'h1);
        host_write(0, 32'h5);
        done_seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            demo_sig = 1; sample = 8'hB0 + 8'(2 * k); tick();
            demo_sig = 0; sample = 8'hB1 + 8'(2 * k); tick();
            sample = 0; tick(); tick();
        end
        host_read(4, d); check("cont_capcnt", d, 32'h4);
        host_read(1, d); check("cont_status", d, 32'h5);
        host_read(256, d); check("cont_ram0", d, 32'hB4);
        host_read(257, d); check("cont_ram1", d, 32'hB5);
        check("cont_no_done", 32'(done_seen), 32'h0);
        host_write(0, 32'h2);
        host_read(1, d); check("abort_status", d, 32'h0);

        host_write(0, 32'h1);
        host_write(261, 32'h55);
        host_read(261, d); check("armed_wr_dropped", d, 32'h15);
        host_write(0, 32'h2);
        host_write(261, 32'h55);
        host_read(261, d); check("idle_wr", d, 32'h55);
        host_write(320, 32'h77);
        host_read(320, d); check("past_ram_rd", d, 32'h0);
        host_read(256, d); check("past_ram_noalias", d, 32'hB4);

        host_write(0, 32'h3);
        host_read(1, d); check("arm_abort", d, 32'h0);
        gb_addr = 0; gb_wdata = 32'h1; gb_we = 1; demo_sig = 1; sample = 8'hEE;
        tick();
        gb_we = 0; tick();
        demo_sig = 0; tick();
        host_read(1, d); check("arm_trig_same", d, 32'h1);
        host_read(256, d); check("arm_trig_noram", d, 32'hB4);
        host_write(0, 32'h2);

        host_write(3, 32'h3f);
        host_write(0, 32'h1);
        demo_sig = 1; sample = 8'hD0; tick();
        demo_sig = 0;
        for (int i = 1; i <= 5; i++) begin sample = 8'hD0 + 8'(i); tick(); end
        sample = 0;
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_done", 32'(done), 32'h0);
        check("async_rst_rvalid", 32'(gb_rvalid), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        host_read(1, d); check("rst2_status", d, 32'h0);
        host_read(4, d); check("rst2_capcnt", d, 32'h0);
        host_read(3, d); check("rst2_caplen", d, 32'h3f);
        host_read(2, d); check("rst2_scratch", d, 32'h42);
        host_read(258, d); check("rst2_ram_kept", d, 32'hD2);
        host_read(262, d); check("rst2_ram_unwritten", d, 32'h16);

        host_write(3, 32'h0);
        host_write(0, 32'h1);
        demo_sig = 1; sample = 8'hC7; tick();
        demo_sig = 0; sample = 8'hC8;
        check("len0_done", 32'(done), 32'h1);
        tick();
        host_read(256, d); check("len0_ram0", d, 32'hC7);
        host_read(257, d); check("len0_ram1", d, 32'hD1);
        host_read(4, d); check("len0_capcnt", d, 32'h1);
        host_read(1, d); check("len0_status", d, 32'h103);
        check("len0_done_hold", 32'(done), 32'h1);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_done_hi", 32'(done), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
